// File: rtl/multichannel_pipelined_convolution.sv
// KxK fixed-point convolution engine that accumulates one window per input channel and emits
// one bias-added, saturated (optionally ReLU'd) pixel per IN_CHANNELS accepted beats.
module multichannel_pipelined_convolution #(
  parameter int KERNEL_SIZE   = 3,
  parameter int DATA_WIDTH    = 16,
  parameter int FRACTION_BITS = 14,
  parameter bit SIGNED        = 1'b1,
  parameter int IN_CHANNELS   = 4,
  parameter bit RELU          = 1'b0
) (
  input  logic                                             clock,
  input  logic                                             reset_n,
  input  logic                                             clear,
  input  logic                                             valid,
  input  logic [DATA_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0]    data,
  input  logic [DATA_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0]    weights,
  input  logic [DATA_WIDTH-1:0]                            bias,
  output logic [DATA_WIDTH-1:0]                            convol_out,
  output logic                                             convol_valid,
  output logic                                             overflow
);

  localparam int DW     = DATA_WIDTH;
  localparam int FB     = FRACTION_BITS;
  localparam int K2     = KERNEL_SIZE * KERNEL_SIZE;
  localparam int LEVELS = $clog2(K2);
  // One guard bit above the nominal widths lets unsigned operands share the signed datapath.
  localparam int SW     = 2 * DW + 1 + LEVELS;
  localparam int ACC_W  = 2 * DW + $clog2(K2 * IN_CHANNELS + 1) + 1;
  localparam int CW     = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1;

  localparam logic [CW-1:0]           CH_LAST = CW'(IN_CHANNELS - 1);
  localparam logic signed [ACC_W-1:0] ONE_W   = {{(ACC_W-1){1'b0}}, 1'b1};
  localparam logic signed [ACC_W-1:0] SAT_HI  = SIGNED ? ((ONE_W <<< (DW - 1)) - ONE_W)
                                                       : ((ONE_W <<< DW) - ONE_W);
  localparam logic signed [ACC_W-1:0] SAT_LO  = SIGNED ? -(ONE_W <<< (DW - 1)) : {ACC_W{1'b0}};

  function automatic logic signed [DW:0] ext(input logic [DW-1:0] x);
    return SIGNED ? $signed({x[DW-1], x}) : $signed({1'b0, x});
  endfunction

  function automatic int lvl_cnt(input int l);
    int n;
    n = K2;
    for (int i = 0; i < l; i++) n = (n + 1) / 2;
    return n;
  endfunction

  function automatic int clamp_idx(input int i);
    return (i < K2) ? i : K2 - 1;
  endfunction

  logic                    accept_s;
  logic [CW-1:0]           ch_r;
  logic                    in_v_r, in_first_r, in_last_r;
  logic [DW*K2-1:0]        in_data_r, in_w_r;
  logic [DW-1:0]           in_bias_r;
  logic signed [SW-1:0]    prod_s [K2];
  logic signed [SW-1:0]    tree_r [LEVELS+1][K2];
  logic [LEVELS:0]         v_r, first_r, last_r;
  logic [DW-1:0]           bias_r [LEVELS+1];
  logic signed [ACC_W-1:0] acc_r, bias_acc_s, sum_acc_s, shifted_s;
  logic                    acc_v_r, acc_last_r;
  logic [DW-1:0]           sat_s, res_s;
  logic                    ovf_s;

  assign accept_s = valid & ~clear;

  // Channel counter and beat capture register; a clear discards any beat in the same cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ch_r       <= {CW{1'b0}};
      in_v_r     <= 1'b0;
      in_first_r <= 1'b0;
      in_last_r  <= 1'b0;
      in_data_r  <= {(DW*K2){1'b0}};
      in_w_r     <= {(DW*K2){1'b0}};
      in_bias_r  <= {DW{1'b0}};
    end else begin
      in_v_r <= accept_s;
      if (accept_s) begin
        in_first_r <= (ch_r == {CW{1'b0}});
        in_last_r  <= (ch_r == CH_LAST);
        in_data_r  <= data;
        in_w_r     <= weights;
        in_bias_r  <= bias;
        ch_r       <= (ch_r == CH_LAST) ? {CW{1'b0}} : ch_r + 1'b1;
      end else if (clear) begin
        ch_r <= {CW{1'b0}};
      end
    end
  end

  // Full-precision lane products.
  always_comb begin
    for (int k = 0; k < K2; k++) begin
      prod_s[k] = SW'(ext(in_data_r[DW*k +: DW])) * SW'(ext(in_w_r[DW*k +: DW]));
    end
  end

  assign sum_acc_s  = ACC_W'(tree_r[LEVELS][0]);
  assign bias_acc_s = ACC_W'(ext(bias_r[LEVELS])) <<< FB;

  // Product stage, adder tree, flag/bias side pipeline and channel accumulator.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v_r        <= {(LEVELS+1){1'b0}};
      first_r    <= {(LEVELS+1){1'b0}};
      last_r     <= {(LEVELS+1){1'b0}};
      acc_r      <= {ACC_W{1'b0}};
      acc_v_r    <= 1'b0;
      acc_last_r <= 1'b0;
      for (int l = 0; l <= LEVELS; l++) begin
        bias_r[l] <= {DW{1'b0}};
        for (int j = 0; j < K2; j++) tree_r[l][j] <= {SW{1'b0}};
      end
    end else begin
      v_r[0]     <= in_v_r & ~clear;
      first_r[0] <= in_first_r;
      last_r[0]  <= in_last_r;
      bias_r[0]  <= in_bias_r;
      for (int k = 0; k < K2; k++) tree_r[0][k] <= prod_s[k];
      for (int l = 0; l < LEVELS; l++) begin
        v_r[l+1]     <= v_r[l] & ~clear;
        first_r[l+1] <= first_r[l];
        last_r[l+1]  <= last_r[l];
        bias_r[l+1]  <= bias_r[l];
        for (int j = 0; j < K2; j++) begin
          if (2 * j + 1 < lvl_cnt(l)) begin
            tree_r[l+1][j] <= tree_r[l][clamp_idx(2*j)] + tree_r[l][clamp_idx(2*j+1)];
          end else if (2 * j < lvl_cnt(l)) begin
            tree_r[l+1][j] <= tree_r[l][clamp_idx(2*j)];
          end else begin
            tree_r[l+1][j] <= {SW{1'b0}};
          end
        end
      end
      acc_v_r    <= v_r[LEVELS] & ~clear;
      acc_last_r <= last_r[LEVELS];
      if (v_r[LEVELS]) begin
        acc_r <= (first_r[LEVELS] ? bias_acc_s : acc_r) + sum_acc_s;
      end
    end
  end

  // Rescale with floor, saturate to the output range, then optional ReLU.
  always_comb begin
    shifted_s = acc_r >>> FB;
    sat_s     = shifted_s[DW-1:0];
    ovf_s     = 1'b0;
    if (shifted_s > SAT_HI) begin
      sat_s = SAT_HI[DW-1:0];
      ovf_s = 1'b1;
    end else if (shifted_s < SAT_LO) begin
      sat_s = SAT_LO[DW-1:0];
      ovf_s = 1'b1;
    end else begin
      sat_s = shifted_s[DW-1:0];
      ovf_s = 1'b0;
    end
    if (RELU && SIGNED && sat_s[DW-1]) begin
      res_s = {DW{1'b0}};
    end else begin
      res_s = sat_s;
    end
  end

  // Output stage; a pixel already in the accumulator is emitted even if clear rises now.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      convol_out   <= {DW{1'b0}};
      convol_valid <= 1'b0;
      overflow     <= 1'b0;
    end else if (acc_v_r && acc_last_r) begin
      convol_out   <= res_s;
      convol_valid <= 1'b1;
      overflow     <= ovf_s;
    end else begin
      convol_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multichannel_pipelined_convolution.sv
// Scoreboard bench: three instances (2 channels, 2 channels with ReLU, 1 channel) share stimulus.
module tb_multichannel_pipelined_convolution;
  localparam int K2 = 9;
  localparam int DW = 16;
  localparam shortint JUNK = 16'sh1234;

  typedef struct packed {
    logic [15:0] out;
    logic        ovf;
    int          due;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n = 1'b1;
  logic clear = 1'b0;
  logic valid = 1'b0;
  logic [DW*K2-1:0] data = {(DW*K2){1'b0}};
  logic [DW*K2-1:0] weights = {(DW*K2){1'b0}};
  logic [DW-1:0] bias = 16'h0000;
  logic [DW-1:0] out0, out1, out2;
  logic v0, v1, v2, ov0, ov1, ov2;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  logic [15:0] last_main = 16'h0000;

  multichannel_pipelined_convolution #(.KERNEL_SIZE(3), .DATA_WIDTH(16), .FRACTION_BITS(14),
    .SIGNED(1'b1), .IN_CHANNELS(2), .RELU(1'b0)) u_main (
    .clock(clock), .reset_n(reset_n), .clear(clear), .valid(valid), .data(data),
    .weights(weights), .bias(bias), .convol_out(out0), .convol_valid(v0), .overflow(ov0));

  multichannel_pipelined_convolution #(.KERNEL_SIZE(3), .DATA_WIDTH(16), .FRACTION_BITS(14),
    .SIGNED(1'b1), .IN_CHANNELS(2), .RELU(1'b1)) u_relu (
    .clock(clock), .reset_n(reset_n), .clear(clear), .valid(valid), .data(data),
    .weights(weights), .bias(bias), .convol_out(out1), .convol_valid(v1), .overflow(ov1));

  multichannel_pipelined_convolution #(.KERNEL_SIZE(3), .DATA_WIDTH(16), .FRACTION_BITS(14),
    .SIGNED(1'b1), .IN_CHANNELS(1), .RELU(1'b0)) u_ch1 (
    .clock(clock), .reset_n(reset_n), .clear(clear), .valid(valid), .data(data),
    .weights(weights), .bias(bias), .convol_out(out2), .convol_valid(v2), .overflow(ov2));

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic int qsize(input int id);
    case (id)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t qfront(input int id);
    case (id)
      0: return q0[0];
      1: return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic qpop(input int id);
    case (id)
      0: void'(q0.pop_front());
      1: void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endtask

  task automatic qpush(input int id, input exp_t e);
    case (id)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // Independent single-beat reference for the 1-channel instance.
  function automatic exp_t c1_model(input shortint d0, input shortint ds, input shortint w0,
                                    input shortint ws, input shortint b, input int due);
    longint s;
    longint r;
    exp_t e;
    s = longint'(b) * 64'sd16384;
    for (int l = 0; l < K2; l++) begin
      s += longint'(shortint'(d0 + l * ds)) * longint'(shortint'(w0 + l * ws));
    end
    r = s >>> 14;
    e.due = due;
    if (r > 64'sd32767) begin
      e.out = 16'h7FFF; e.ovf = 1'b1;
    end else if (r < -64'sd32768) begin
      e.out = 16'h8000; e.ovf = 1'b1;
    end else begin
      e.out = 16'(r); e.ovf = 1'b0;
    end
    return e;
  endfunction

  task automatic check_pulse(input int id, input string name, input logic v,
                             input logic [15:0] o, input logic ov);
    exp_t e;
    if (v) begin
      n_vec++;
      if (qsize(id) == 0) begin
        n_err++;
        $display("FAIL %s spurious pulse cycle=%0d out=%h ovf=%0b", name, cyc, o, ov);
      end else begin
        e = qfront(id);
        qpop(id);
        if (e.due != cyc || o != e.out || ov != e.ovf) begin
          n_err++;
          $display("FAIL %s pulse: got out=%h ovf=%0b cycle=%0d, expected out=%h ovf=%0b cycle=%0d",
                   name, o, ov, cyc, e.out, e.ovf, e.due);
        end
      end
    end else if (qsize(id) != 0) begin
      e = qfront(id);
      if (e.due <= cyc) begin
        n_vec++;
        n_err++;
        qpop(id);
        $display("FAIL %s missing pulse: none at cycle=%0d, expected out=%h ovf=%0b",
                 name, cyc, e.out, e.ovf);
      end
    end
  endtask

  // Monitor: pops expected pixels as pulses appear and checks the main output holds between pulses.
  always @(negedge clock) begin
    if (!reset_n) begin
      last_main = 16'h0000;
    end else begin
      check_pulse(0, "main", v0, out0, ov0);
      check_pulse(1, "relu", v1, out1, ov1);
      check_pulse(2, "ch1", v2, out2, ov2);
      if (v0) begin
        last_main = out0;
      end else begin
        n_vec++;
        if (out0 != last_main) begin
          n_err++;
          $display("FAIL main hold: out=%h, expected held %h at cycle=%0d", out0, last_main, cyc);
        end
      end
    end
  end

  task automatic check_eq(input string name, input logic [15:0] act, input logic [15:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp_v);
    end
  endtask

  task automatic check_reset_state();
    check_eq("main out reset", out0, 16'h0000);
    check_eq("main valid reset", {15'd0, v0}, 16'h0000);
    check_eq("main ovf reset", {15'd0, ov0}, 16'h0000);
    check_eq("relu out reset", out1, 16'h0000);
    check_eq("relu valid reset", {15'd0, v1}, 16'h0000);
    check_eq("ch1 out reset", out2, 16'h0000);
    check_eq("ch1 valid reset", {15'd0, v2}, 16'h0000);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      valid = 1'b0;
      clear = 1'b0;
    end
  endtask

  task automatic beat(input shortint d0, input shortint ds, input shortint w0, input shortint ws,
                      input shortint b, input bit clr, output int acc_cyc);
    @(negedge clock);
    for (int l = 0; l < K2; l++) begin
      data[16*l +: 16]    = 16'(d0 + l * ds);
      weights[16*l +: 16] = 16'(w0 + l * ws);
    end
    bias    = b;
    valid   = 1'b1;
    clear   = clr;
    acc_cyc = cyc + 1;
  endtask

  // One 2-channel pixel (same window on both beats); expected values are hand-computed by the caller.
  task automatic pixel(input shortint d0, input shortint ds, input shortint w0, input shortint ws,
                       input shortint b, input int gap, input logic [15:0] eo, input logic eov,
                       input logic [15:0] ro, input logic rov);
    int c;
    exp_t e;
    beat(d0, ds, w0, ws, b, 1'b0, c);
    qpush(2, c1_model(d0, ds, w0, ws, b, c + 7));
    if (gap > 0) idle(gap);
    beat(d0, ds, w0, ws, JUNK, 1'b0, c);
    qpush(2, c1_model(d0, ds, w0, ws, JUNK, c + 7));
    e.out = eo; e.ovf = eov; e.due = c + 7;
    qpush(0, e);
    e.out = ro; e.ovf = rov;
    qpush(1, e);
  endtask

  initial begin
    int c;
    #2 reset_n = 1'b0;
    #1 check_reset_state();
    idle(2);
    reset_n = 1'b1;
    idle(1);

    // 0.25*0.25*18 + 0.25 bias = 1.375
    pixel(16'sd4096, 16'sd0, 16'sd4096, 16'sd0, 16'sd4096, 0, 16'h5800, 1'b0, 16'h5800, 1'b0);
    idle(2);
    // 2.25 saturates high; -4.5 saturates low (ReLU zeroes it but keeps overflow)
    pixel(16'sd8192, 16'sd0, 16'sd4096, 16'sd0, 16'sd0, 0, 16'h7FFF, 1'b1, 16'h7FFF, 1'b1);
    pixel(16'sd8192, 16'sd0, -16'sd8192, 16'sd0, 16'sd0, 0, 16'h8000, 1'b1, 16'h0000, 1'b1);
    idle(1);
    // -1.125 in range; ReLU clamps to 0 with no overflow
    pixel(16'sd4096, 16'sd0, -16'sd4096, 16'sd0, 16'sd0, 0, 16'hB800, 1'b0, 16'h0000, 1'b0);
    // Ramp window exercises per-lane packing: sum l*1024*(4096-512l) twice -> 5376
    pixel(16'sd0, 16'sd1024, 16'sd4096, -16'sd512, 16'sd0, 0, 16'h1500, 1'b0, 16'h1500, 1'b0);
    idle(3);
    // Gap of 3 idle cycles between the two beats of a pixel
    pixel(16'sd4096, 16'sd0, 16'sd4096, 16'sd0, 16'sd4096, 3, 16'h5800, 1'b0, 16'h5800, 1'b0);
    idle(4);
    // Back-to-back pixels with distinct biases: 1.125 + bias
    pixel(16'sd4096, 16'sd0, 16'sd4096, 16'sd0, 16'sd0, 0, 16'h4800, 1'b0, 16'h4800, 1'b0);
    pixel(16'sd4096, 16'sd0, 16'sd4096, 16'sd0, 16'sd4096, 0, 16'h5800, 1'b0, 16'h5800, 1'b0);
    pixel(16'sd4096, 16'sd0, 16'sd4096, 16'sd0, -16'sd8192, 0, 16'h2800, 1'b0, 16'h2800, 1'b0);
    pixel(16'sd4096, 16'sd0, 16'sd4096, 16'sd0, 16'sd16384, 0, 16'h7FFF, 1'b1, 16'h7FFF, 1'b1);
    idle(10);

    // Lone beat aborted by a clear that also carries a (discarded) beat, then a normal pixel
    beat(16'sd8192, 16'sd0, 16'sd8192, 16'sd0, 16'sd8192, 1'b0, c);
    beat(16'sd8192, 16'sd0, 16'sd8192, 16'sd0, 16'sd8192, 1'b1, c);
    pixel(16'sd4096, 16'sd0, 16'sd4096, 16'sd0, 16'sd4096, 0, 16'h5800, 1'b0, 16'h5800, 1'b0);
    idle(12);

    // Asynchronous reset in the middle of a pixel
    beat(16'sd8192, 16'sd0, 16'sd8192, 16'sd0, 16'sd8192, 1'b0, c);
    idle(1);
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1 check_reset_state();
    idle(2);
    reset_n = 1'b1;
    pixel(16'sd4096, 16'sd0, 16'sd4096, 16'sd0, 16'sd4096, 0, 16'h5800, 1'b0, 16'h5800, 1'b0);
    idle(12);

    for (int id = 0; id < 3; id++) begin
      while (qsize(id) != 0) begin
        n_vec++;
        n_err++;
        $display("FAIL drain: instance %0d still expects out=%h at cycle=%0d",
                 id, qfront(id).out, qfront(id).due);
        qpop(id);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
